ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Built-in self-test controller placed directly upstream of the dual_port_ram block.
- Runs a March C- algorithm on one start pulse: writes through port A, reads back through port B, and compares every read against the expected background.
- Reports pass/fail plus the first failing address and data.
- Used at bring-up and in the verification environment; in mission mode it sits idle, with the RAM muxed to functional logic outside this block.

Parameters:
- DEPTH, 16, number of RAM words; a power of two, ≥ 2.
- WIDTH, 16, bits per word.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  single clock for the controller and the RAM.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; starts a test when sampled high in IDLE, DONE or FAIL.
- busy  out  1  high while the test is running.
- done  out  1  test finished; held until the next start.
- pass  out  1  with done, high if no mismatch; held.
- fail  out  1  mismatch detected; held until the next start.
- fail_addr  out  AW  address of the first mismatch.
- fail_exp  out  WIDTH  expected word at the first mismatch.
- fail_got  out  WIDTH  read word at the first mismatch.
- ram_w_en_a  out  1  RAM port A write enable.
- ram_addr_a  out  AW  RAM port A address.
- ram_data_in_a  out  WIDTH  RAM port A write data.
- ram_w_en_b  out  1  RAM port B write enable; tied 0, port B is read-only.
- ram_addr_b  out  AW  RAM port B address.
- ram_data_out_b  in  WIDTH  RAM port B registered read data, valid 1 cycle after the address.

Behaviour:
- RAM contract:
  - Port B read is registered: the address presented at edge k returns data after edge k.
  - A read and a port-A write to the same address at the same edge return the old data (read-before-write).
- Reset: all outputs 0, ram_addr_* 0, FSM in IDLE, comparator-valid cleared. Reset mid-test aborts immediately with no done or fail.
- FSM states:
  - IDLE -> RUN on start. done, pass, fail and fail_* are cleared on entry to RUN.
  - RUN steps elem 0..5 × addr. Last op of elem 5 -> DRAIN.
  - DRAIN (1 cycle, final compare) -> DONE with pass=1.
  - Any mismatch in RUN or DRAIN -> FAIL.
  - DONE/FAIL -> RUN on start. start is ignored in RUN and DRAIN.
- March elements; one address per cycle, read and write issued in the same cycle. Z is all zeros, O is all ones.
  - e0 ascending: w Z.
  - e1 ascending: r Z, w O.
  - e2 ascending: r O, w Z.
  - e3 descending: r Z, w O.
  - e4 descending: r O, w Z.
  - e5 descending: r Z, no write.
- Addressing:
  - Ascending elements run 0..DEPTH-1; descending elements run DEPTH-1..0.
  - ram_addr_a equals ram_addr_b whenever both are used.
  - ram_w_en_a is high only in write cycles of e0–e4.
  - In e0 port B is not compared.
- Compare pipeline:
  - Each read registers {valid, addr, expected} at issue.
  - On the next cycle ram_data_out_b is compared against expected.
  - Element boundaries need no bubble. Example: the e2 write of DEPTH-1 at edge k is followed by the e3 read of DEPTH-1 at edge k+1, which returns the new data.
- Mismatch handling:
  - Capture fail_addr, fail_exp and fail_got, set fail=1, go to FAIL.
  - ram_w_en_a drops on the next cycle.
  - At most one further op, already issued in the compare cycle, reaches the RAM.
- Timing:
  - busy rises the cycle after start is sampled.
  - busy stays high for 6·DEPTH + 1 cycles on a pass (97 cycles at DEPTH=16).
  - done rises in the cycle busy falls.
- Counters: the address counter wraps naturally (modulo DEPTH). The element counter is 3 bits; values 6–7 are unreachable and treated as DRAIN.

Decomposition:
- Package ram_bist_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE, FAIL};
  - per-element constant tables: direction, read-enable, expected bit, write-enable, write bit;
  - NUM_ELEM = 6.
- Sub-module ram_bist_cmp: the registered compare stage (valid/addr/exp in, mismatch + captured fail_* out).

Test Plan:
- Fault-free dual_port_ram, DEPTH=16, WIDTH=16, start pulse -> busy high for 97 cycles, then done=1, pass=1, fail=0; memory holds 0000 everywhere.
- Bench RAM model with bit 3 of addr 5 stuck-at-1 -> fail in e1: fail_addr=5, fail_exp=0000, fail_got=0008, done=0, busy=0 next cycle.
- Model with bit 0 of addr 15 stuck-at-0 -> first fail in e2: fail_addr=15, fail_exp=FFFF, fail_got=FFFE.
- Coupling fault (write 1 to addr 2 sets bit 7 of addr 3) -> detected in e1 at addr 3: exp 0000, got 0080.
- start re-asserted during RUN -> ignored, cycle count still 97. start in DONE -> new run; done, pass and fail_* cleared on the first busy cycle.
- rst_n low at cycle 40 of a run -> all outputs 0 and ram_w_en_a=0 immediately. After release with no start, block stays IDLE. A following start gives a full 97-cycle pass.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// March C- element tables and controller state type shared by the RAM BIST blocks.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StDone,
    StFail
  } bist_state_e;

  localparam int unsigned NUM_ELEM  = 6;
  localparam logic [2:0]  LAST_ELEM = 3'(NUM_ELEM - 1);

  // Bit i describes march element i; bits 6-7 stay 0 so stray counter values issue nothing.
  localparam logic [7:0] ELEM_DESC = 8'b0011_1000;  // descending address order
  localparam logic [7:0] ELEM_RD   = 8'b0011_1110;  // element reads and compares
  localparam logic [7:0] ELEM_EXP  = 8'b0001_0100;  // expected background bit
  localparam logic [7:0] ELEM_WR   = 8'b0001_1111;  // element writes
  localparam logic [7:0] ELEM_WBIT = 8'b0000_1010;  // written background bit

  function automatic logic elem_bit(logic [7:0] tbl, logic [2:0] elem);
    return tbl[elem];
  endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// Control, status and RAM-port bundle between the March BIST controller and its environment.
interface ram_march_bist_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [AW-1:0]    fail_addr;
  logic [WIDTH-1:0] fail_exp;
  logic [WIDTH-1:0] fail_got;
  logic             ram_w_en_a;
  logic [AW-1:0]    ram_addr_a;
  logic [WIDTH-1:0] ram_data_in_a;
  logic             ram_w_en_b;
  logic [AW-1:0]    ram_addr_b;
  logic [WIDTH-1:0] ram_data_out_b;

  modport master (
    input  start, ram_data_out_b,
    output busy, done, pass, fail, fail_addr, fail_exp, fail_got,
    output ram_w_en_a, ram_addr_a, ram_data_in_a, ram_w_en_b, ram_addr_b
  );

  modport slave (
    output start, ram_data_out_b,
    input  busy, done, pass, fail, fail_addr, fail_exp, fail_got,
    input  ram_w_en_a, ram_addr_a, ram_data_in_a, ram_w_en_b, ram_addr_b
  );

endinterface

// File: rtl/ram_bist_cmp.sv
// Registered read-compare stage: holds the issued read one cycle, compares against port B data
// and latches the first mismatch seen while capture is enabled.
module ram_bist_cmp #(
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             cap_en_i,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    issue_addr_i,
  input  logic [WIDTH-1:0] issue_exp_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic             mismatch_o,
  output logic [AW-1:0]    fail_addr_o,
  output logic [WIDTH-1:0] fail_exp_o,
  output logic [WIDTH-1:0] fail_got_o
);

  logic             valid_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] exp_q;
  logic [AW-1:0]    fail_addr_q;
  logic [WIDTH-1:0] fail_exp_q;
  logic [WIDTH-1:0] fail_got_q;

  assign mismatch_o  = valid_q && (rdata_i != exp_q);
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_got_o  = fail_got_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      addr_q      <= '0;
      exp_q       <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      valid_q <= issue_valid_i;
      addr_q  <= issue_addr_i;
      exp_q   <= issue_exp_i;
      if (clear_i) begin
        fail_addr_q <= '0;
        fail_exp_q  <= '0;
        fail_got_q  <= '0;
      end else if (cap_en_i && mismatch_o) begin
        fail_addr_q <= addr_q;
        fail_exp_q  <= exp_q;
        fail_got_q  <= rdata_i;
      end
    end
  end

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST controller: writes through RAM port A, reads back through port B and reports
// pass/fail with the first failing address and data.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  ram_march_bist_if.master bus_io
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

  bist_state_e   state_q;
  logic [2:0]    elem_q;
  logic [AW-1:0] addr_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic          fail_q;

  logic             op_active;
  logic             desc;
  logic             rd_en;
  logic             wr_en;
  logic             last_addr;
  logic             start_acc;
  logic             cap_en;
  logic             mismatch;
  logic [2:0]       elem_nxt;
  logic [AW-1:0]    first_addr_nxt;
  logic [WIDTH-1:0] exp_word;
  logic [WIDTH-1:0] wr_word;

  always_comb begin
    op_active      = (state_q == StRun) && (elem_q <= LAST_ELEM);
    desc           = elem_bit(ELEM_DESC, elem_q);
    rd_en          = op_active && elem_bit(ELEM_RD, elem_q);
    wr_en          = op_active && elem_bit(ELEM_WR, elem_q);
    exp_word       = {WIDTH{elem_bit(ELEM_EXP, elem_q)}};
    wr_word        = {WIDTH{elem_bit(ELEM_WBIT, elem_q)}};
    last_addr      = desc ? (addr_q == '0) : (addr_q == ADDR_MAX);
    elem_nxt       = elem_q + 3'd1;
    first_addr_nxt = elem_bit(ELEM_DESC, elem_nxt) ? ADDR_MAX : '0;
    start_acc      = bus_io.start && (state_q inside {StIdle, StDone, StFail});
    cap_en         = state_q inside {StRun, StDrain};
  end

  // Read and write share one address, so a read returns the word before this cycle's write.
  assign bus_io.ram_w_en_a    = wr_en;
  assign bus_io.ram_addr_a    = op_active ? addr_q : '0;
  assign bus_io.ram_data_in_a = wr_en ? wr_word : '0;
  assign bus_io.ram_w_en_b    = 1'b0;
  assign bus_io.ram_addr_b    = op_active ? addr_q : '0;

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.pass = pass_q;
  assign bus_io.fail = fail_q;

  ram_bist_cmp #(
    .AW   (AW),
    .WIDTH(WIDTH)
  ) u_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_acc),
    .cap_en_i     (cap_en),
    .issue_valid_i(rd_en),
    .issue_addr_i (addr_q),
    .issue_exp_i  (exp_word),
    .rdata_i      (bus_io.ram_data_out_b),
    .mismatch_o   (mismatch),
    .fail_addr_o  (bus_io.fail_addr),
    .fail_exp_o   (bus_io.fail_exp),
    .fail_got_o   (bus_io.fail_got)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      elem_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone, StFail: begin
          if (start_acc) begin
            state_q <= StRun;
            elem_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
          end
        end
        StRun: begin
          if (mismatch) begin
            state_q <= StFail;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end else if (elem_q > LAST_ELEM) begin
            state_q <= StDrain;
          end else if (last_addr) begin
            if (elem_q == LAST_ELEM) begin
              state_q <= StDrain;
            end else begin
              elem_q <= elem_nxt;
              addr_q <= first_addr_nxt;
            end
          end else begin
            addr_q <= desc ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
        StDrain: begin
          busy_q <= 1'b0;
          if (mismatch) begin
            state_q <= StFail;
            fail_q  <= 1'b1;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: faulty-RAM model on the ports plus a behavioural March C- reference.
module tb_ram_march_bist;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int          PASS_CYC = 6 * DEPTH + 1;
  localparam int          MAX_CYC  = 400;

  logic clk;
  logic rst_n;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   proto_err = 0;

  ram_march_bist_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  ram_march_bist #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fault model: 0 none, 1 stuck-at bit, 2 coupling (nonzero write to aggr sets a victim bit).
  int   f_kind = 0;
  int   f_addr = 0;
  int   f_bit  = 0;
  logic f_val  = 1'b0;
  int   f_aggr = 0;
  int   f_vict = 1;

  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];

  // March C-: direction (1 = descending), read background (-1 none), write background (-1 none).
  int m_dir [6] = '{0, 0, 0, 1, 1, 1};
  int m_rd  [6] = '{-1, 0, 1, 0, 1, 0};
  int m_wr  [6] = '{0, 1, 0, 1, 0, -1};

  function automatic logic [WIDTH-1:0] stuck(int a, logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = d;
    if (f_kind == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  function automatic void ram_wr(int a, logic [WIDTH-1:0] d);
    ram_mem[a] = stuck(a, d);
    if (f_kind == 2 && a == f_aggr && d != '0) ram_mem[f_vict][f_bit] = 1'b1;
  endfunction

  function automatic void ref_wr(int a, logic [WIDTH-1:0] d);
    ref_mem[a] = stuck(a, d);
    if (f_kind == 2 && a == f_aggr && d != '0) ref_mem[f_vict][f_bit] = 1'b1;
  endfunction

  // Dual-port RAM: registered port-B read, read-before-write against port A.
  always @(posedge clk) begin
    bus.ram_data_out_b <= stuck(int'(bus.ram_addr_b), ram_mem[bus.ram_addr_b]);
    if (bus.ram_w_en_a === 1'b1) ram_wr(int'(bus.ram_addr_a), bus.ram_data_in_a);
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.ram_w_en_b !== 1'b0 || (bus.ram_w_en_a === 1'b1 &&
        (bus.busy !== 1'b1 || bus.ram_addr_a !== bus.ram_addr_b))))
      proto_err <= proto_err + 1;
  end

  // Runs the algorithm op by op; r_op is the index of the failing op when r_pass is 0.
  task automatic ref_march(output bit r_pass, output int r_op, output logic [AW-1:0] r_addr,
                           output logic [WIDTH-1:0] r_exp, output logic [WIDTH-1:0] r_got);
    int               a;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] got;
    r_pass = 1'b1;
    r_op   = 0;
    r_addr = '0;
    r_exp  = '0;
    r_got  = '0;
    for (int el = 0; el < 6 && r_pass; el++) begin
      for (int i = 0; i < int'(DEPTH) && r_pass; i++) begin
        a = (m_dir[el] == 1) ? int'(DEPTH) - 1 - i : i;
        if (m_rd[el] >= 0) begin
          e   = (m_rd[el] == 1) ? '1 : '0;
          got = stuck(a, ref_mem[a]);
          if (got !== e) begin
            r_pass = 1'b0;
            r_addr = AW'(a);
            r_exp  = e;
            r_got  = got;
          end
        end
        if (r_pass) begin
          if (m_wr[el] >= 0) ref_wr(a, (m_wr[el] == 1) ? '1 : '0);
          r_op++;
        end
      end
    end
  endtask

  task automatic set_fault(input int kind, input int addr, input int b, input logic val,
                           input int aggr, input int vict);
    f_kind = kind;
    f_addr = addr;
    f_bit  = b;
    f_val  = val;
    f_aggr = aggr;
    f_vict = vict;
  endtask

  // Pulses start, then counts busy cycles; re_at > 0 re-asserts start for 8 cycles mid-run.
  task automatic do_run(input int re_at, output int cyc, output bit to);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < MAX_CYC) begin
      cyc++;
      bus.start = (re_at > 0 && cyc >= re_at && cyc < re_at + 8);
      @(negedge clk);
    end
    bus.start = 1'b0;
    to = (cyc >= MAX_CYC);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.pass, bus.fail, bus.ram_w_en_a, bus.ram_w_en_b} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got busy/done/pass/fail/wena/wenb=%b%b%b%b%b%b want 000000",
               bus.busy, bus.done, bus.pass, bus.fail, bus.ram_w_en_a, bus.ram_w_en_b);
    end
    n_checks++;
    if ({bus.fail_addr, bus.fail_exp, bus.fail_got} !== '0) begin
      n_errors++;
      $display("FAIL reset_fail_info: got addr=%h exp=%h got=%h want 0", bus.fail_addr,
               bus.fail_exp, bus.fail_got);
    end
    n_checks++;
    if ({bus.ram_addr_a, bus.ram_addr_b, bus.ram_data_in_a} !== '0) begin
      n_errors++;
      $display("FAIL reset_ram_port: got addr_a=%h addr_b=%h din=%h want 0", bus.ram_addr_a,
               bus.ram_addr_b, bus.ram_data_in_a);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.ram_w_en_a} !== 3'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got busy/done/wena=%b%b%b want 000", bus.busy, bus.done,
               bus.ram_w_en_a);
    end
  endtask

  task automatic test_fault_free();
    int               cyc;
    bit               to;
    bit               r_pass;
    int               r_op;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_got;
    set_fault(0, 0, 0, 1'b0, 0, 1);
    ref_march(r_pass, r_op, r_addr, r_exp, r_got);
    do_run(0, cyc, to);
    n_checks++;
    if (to || cyc != PASS_CYC) begin
      n_errors++;
      $display("FAIL pass_busy_cycles: got %0d (timeout=%0d) want %0d", cyc, to, PASS_CYC);
    end
    n_checks++;
    if ({bus.done, bus.pass, bus.fail, bus.busy} !== {r_pass, r_pass, !r_pass, 1'b0}) begin
      n_errors++;
      $display("FAIL pass_flags: got done/pass/fail/busy=%b%b%b%b want %b%b%b0", bus.done,
               bus.pass, bus.fail, bus.busy, r_pass, r_pass, !r_pass);
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      n_checks++;
      if (ram_mem[a] !== ref_mem[a]) begin
        n_errors++;
        $display("FAIL final_mem[%0d]: got %h want %h", a, ram_mem[a], ref_mem[a]);
      end
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({bus.done, bus.pass} !== 2'b11) begin
      n_errors++;
      $display("FAIL done_held: got done/pass=%b%b want 11", bus.done, bus.pass);
    end
  endtask

  task automatic test_directed_faults();
    int               cfg [3][6] = '{'{1, 5, 3, 1, 0, 1}, '{1, 15, 0, 0, 0, 1},
                                     '{2, 0, 7, 0, 2, 3}};
    int               cyc;
    int               exp_cyc;
    bit               to;
    bit               r_pass;
    int               r_op;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_got;
    for (int t = 0; t < 3; t++) begin
      set_fault(cfg[t][0], cfg[t][1], cfg[t][2], cfg[t][3] != 0, cfg[t][4], cfg[t][5]);
      ref_march(r_pass, r_op, r_addr, r_exp, r_got);
      exp_cyc = r_pass ? PASS_CYC : r_op + 2;
      do_run(0, cyc, to);
      n_checks++;
      if (to || cyc != exp_cyc) begin
        n_errors++;
        $display("FAIL fault%0d_busy_cycles: got %0d want %0d", t, cyc, exp_cyc);
      end
      n_checks++;
      if ({bus.done, bus.pass, bus.fail, bus.busy} !== {r_pass, r_pass, !r_pass, 1'b0}) begin
        n_errors++;
        $display("FAIL fault%0d_flags: got done/pass/fail/busy=%b%b%b%b want %b%b%b0", t,
                 bus.done, bus.pass, bus.fail, bus.busy, r_pass, r_pass, !r_pass);
      end
      n_checks++;
      if ({bus.fail_addr, bus.fail_exp, bus.fail_got} !== {r_addr, r_exp, r_got}) begin
        n_errors++;
        $display("FAIL fault%0d_info: got addr=%h exp=%h got=%h want addr=%h exp=%h got=%h", t,
                 bus.fail_addr, bus.fail_exp, bus.fail_got, r_addr, r_exp, r_got);
      end
    end
  endtask

  task automatic test_random_faults();
    int               cyc;
    int               exp_cyc;
    bit               to;
    bit               r_pass;
    int               r_op;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_got;
    int               ag;
    for (int t = 0; t < 12; t++) begin
      ag = int'($urandom_range(0, DEPTH - 1));
      set_fault(int'($urandom_range(0, 2)), int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(0, WIDTH - 1)), 1'($urandom_range(0, 1)), ag,
                (ag + int'($urandom_range(1, DEPTH - 1))) % int'(DEPTH));
      ref_march(r_pass, r_op, r_addr, r_exp, r_got);
      exp_cyc = r_pass ? PASS_CYC : r_op + 2;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(0, cyc, to);
      n_checks++;
      if (to || cyc != exp_cyc) begin
        n_errors++;
        $display("FAIL rand%0d_busy_cycles: got %0d want %0d (kind %0d)", t, cyc, exp_cyc,
                 f_kind);
      end
      n_checks++;
      if ({bus.done, bus.pass, bus.fail, bus.fail_addr, bus.fail_exp, bus.fail_got} !==
          {r_pass, r_pass, !r_pass, r_addr, r_exp, r_got}) begin
        n_errors++;
        $display("FAIL rand%0d_result: got d/p/f=%b%b%b %h/%h/%h want %b%b%b %h/%h/%h", t,
                 bus.done, bus.pass, bus.fail, bus.fail_addr, bus.fail_exp, bus.fail_got,
                 r_pass, r_pass, !r_pass, r_addr, r_exp, r_got);
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit to;
    set_fault(0, 0, 0, 1'b0, 0, 1);
    do_run(30, cyc, to);
    n_checks++;
    if (to || cyc != PASS_CYC) begin
      n_errors++;
      $display("FAIL start_in_run_cycles: got %0d want %0d", cyc, PASS_CYC);
    end
    n_checks++;
    if ({bus.done, bus.pass, bus.fail} !== 3'b110) begin
      n_errors++;
      $display("FAIL start_in_run_flags: got done/pass/fail=%b%b%b want 110", bus.done,
               bus.pass, bus.fail);
    end
  endtask

  task automatic test_restart();
    int cyc;
    bit to;
    set_fault(1, 9, 12, 1'b1, 0, 1);
    do_run(0, cyc, to);
    n_checks++;
    if (bus.fail !== 1'b1 || bus.fail_addr !== AW'(9)) begin
      n_errors++;
      $display("FAIL restart_setup: got fail=%b addr=%h want 1 9", bus.fail, bus.fail_addr);
    end
    set_fault(0, 0, 0, 1'b0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if ({bus.busy, bus.done, bus.pass, bus.fail} !== 4'b1000 ||
          {bus.fail_addr, bus.fail_exp, bus.fail_got} !== '0) begin
        n_errors++;
        $display("FAIL restart%0d_clear: got b/d/p/f=%b%b%b%b info=%h/%h/%h want 1000 0/0/0", k,
                 bus.busy, bus.done, bus.pass, bus.fail, bus.fail_addr, bus.fail_exp,
                 bus.fail_got);
      end
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < MAX_CYC) begin
        cyc++;
        @(negedge clk);
      end
      n_checks++;
      if (cyc != PASS_CYC || {bus.done, bus.pass, bus.fail} !== 3'b110) begin
        n_errors++;
        $display("FAIL restart%0d_result: got cycles=%0d d/p/f=%b%b%b want %0d 110", k, cyc,
                 bus.done, bus.pass, bus.fail, PASS_CYC);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit to;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (39) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.ram_w_en_a !== 1'b1) begin
      n_errors++;
      $display("FAIL midrun_writing: got busy=%b wena=%b want 1 1", bus.busy, bus.ram_w_en_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.pass, bus.fail, bus.ram_w_en_a, bus.ram_addr_a} !== '0) begin
      n_errors++;
      $display("FAIL midrun_reset: got b/d/p/f/wena=%b%b%b%b%b addr=%h want all 0", bus.busy,
               bus.done, bus.pass, bus.fail, bus.ram_w_en_a, bus.ram_addr_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.fail, bus.ram_w_en_a} !== 4'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle: got b/d/f/wena=%b%b%b%b want 0000", bus.busy, bus.done,
               bus.fail, bus.ram_w_en_a);
    end
    do_run(0, cyc, to);
    n_checks++;
    if (to || cyc != PASS_CYC || bus.pass !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_run: got cycles=%0d pass=%b want %0d 1", cyc, bus.pass, PASS_CYC);
    end
  endtask

  task automatic test_port_rules();
    n_checks++;
    if (proto_err != 0) begin
      n_errors++;
      $display("FAIL port_rules: got %0d violating cycles want 0", proto_err);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_fault_free();
    test_directed_faults();
    test_random_faults();
    test_start_ignored();
    test_restart();
    test_reset_mid_run();
    test_port_rules();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
